// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style interrupt sequencing slice.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } picState_t;

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  localparam logic [3:0] NO_LEVEL       = 4'd8;

  localparam int VECTOR_BASE_W = 5;
  localparam int LEVEL_W       = 3;
  localparam int VECTOR_W      = VECTOR_BASE_W + LEVEL_W;

  // One-hot select of an interrupt level.
  function automatic logic [7:0] levelMask(input logic [LEVEL_W-1:0] level);
    return 8'd1 << level;
  endfunction

endpackage

// File: rtl/pic_priority_encoder8.sv
// Fixed-priority encoder: reports the lowest set bit (bit 0 = highest priority).
module pic_priority_encoder8
  import pic_pkg::*;
(
  input  logic [7:0]         req,
  output logic [LEVEL_W-1:0] index,
  output logic               valid
);

  // Lowest set index wins; an all-zero input reports invalid.
  always_comb begin
    index = 3'd0;
    valid = 1'b1;
    casez (req)
      8'b???????1: index = 3'd0;
      8'b??????10: index = 3'd1;
      8'b?????100: index = 3'd2;
      8'b????1000: index = 3'd3;
      8'b???10000: index = 3'd4;
      8'b??100000: index = 3'd5;
      8'b?1000000: index = 3'd6;
      8'b10000000: index = 3'd7;
      default: begin
        index = 3'd0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/interrupt_sequence_controller.sv
// One interrupt acknowledge sequence of an 8259A-style PIC: IRR capture, fixed
// priority against the ISR, INT generation, two-pulse INTA handshake and EOI.
module interrupt_sequence_controller
  import pic_pkg::*;
#(
  parameter bit EDGE_TRIGGERED = 1'b0,
  parameter bit AUTO_EOI       = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               IR0_to_IR7,
  input  logic [7:0]               bitToMask,
  input  logic                     INTA_n,
  input  logic                     EOI,
  input  logic [VECTOR_BASE_W-1:0] vectorBase,
  output logic                     INT,
  output logic [VECTOR_W-1:0]      dataOut,
  output logic                     dataOutValid,
  output logic [7:0]               IRR,
  output logic [7:0]               ISR,
  output logic [LEVEL_W-1:0]       servicedLevel
);

  picState_t          state;
  picState_t          stateNext;
  logic               intaPrev;
  logic [7:0]         irPrev;
  logic               spurious;
  logic               spuriousNext;
  logic               intaFall;
  logic               intaRise;
  logic [LEVEL_W-1:0] pIndex;
  logic               pValid;
  logic [LEVEL_W-1:0] sIndex;
  logic               sValid;
  logic [3:0]         sLevel;
  logic               intNext;
  logic               ackSet;
  logic [LEVEL_W-1:0] ackLevel;
  logic               loadVector;
  logic               dropValid;
  logic               autoClear;
  logic [7:0]         irrCapture;
  logic [7:0]         irrNext;
  logic [7:0]         isrNext;

  pic_priority_encoder8 irrEncoder (
    .req   (IRR),
    .index (pIndex),
    .valid (pValid)
  );

  pic_priority_encoder8 isrEncoder (
    .req   (ISR),
    .index (sIndex),
    .valid (sValid)
  );

  assign intaFall = intaPrev & ~INTA_n;
  assign intaRise = ~intaPrev & INTA_n;
  assign sLevel   = sValid ? {1'b0, sIndex} : NO_LEVEL;
  assign intNext  = (state == IDLE) && pValid && ({1'b0, pIndex} < sLevel);

  // Handshake sequencing; an empty IRR at the first INTA fall is serviced as level 7.
  always_comb begin
    stateNext    = state;
    spuriousNext = spurious;
    ackSet       = 1'b0;
    ackLevel     = servicedLevel;
    loadVector   = 1'b0;
    dropValid    = 1'b0;
    autoClear    = 1'b0;
    case (state)
      IDLE: begin
        if (intaFall) begin
          stateNext    = ACK1;
          ackSet       = pValid;
          ackLevel     = pValid ? pIndex : SPURIOUS_LEVEL;
          spuriousNext = ~pValid;
        end else begin
          stateNext = IDLE;
        end
      end
      ACK1: begin
        if (intaRise) stateNext = WAIT2;
        else          stateNext = ACK1;
      end
      WAIT2: begin
        if (intaFall) begin
          stateNext  = ACK2;
          loadVector = 1'b1;
        end else begin
          stateNext = WAIT2;
        end
      end
      ACK2: begin
        if (intaRise) begin
          stateNext = IDLE;
          dropValid = 1'b1;
          autoClear = AUTO_EOI && !spurious;
        end else begin
          stateNext = ACK2;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request capture; the acknowledge clear is applied last so it beats a fresh set.
  always_comb begin
    irrCapture = IR0_to_IR7 & ~bitToMask;
    if (EDGE_TRIGGERED) begin
      irrCapture = (IRR | (IR0_to_IR7 & ~irPrev)) & IR0_to_IR7 & ~bitToMask;
    end else begin
      irrCapture = IR0_to_IR7 & ~bitToMask;
    end
    irrNext = irrCapture & ~(ackSet ? levelMask(ackLevel) : 8'h00);
    isrNext = ISR
            & ~((EOI && sValid) ? levelMask(sIndex) : 8'h00)
            & ~(autoClear ? levelMask(servicedLevel) : 8'h00);
    isrNext = isrNext | (ackSet ? levelMask(ackLevel) : 8'h00);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      intaPrev      <= 1'b1;
      irPrev        <= 8'h00;
      spurious      <= 1'b0;
      INT           <= 1'b0;
      dataOut       <= 8'h00;
      dataOutValid  <= 1'b0;
      IRR           <= 8'h00;
      ISR           <= 8'h00;
      servicedLevel <= 3'd0;
    end else begin
      state         <= stateNext;
      intaPrev      <= INTA_n;
      irPrev        <= IR0_to_IR7;
      spurious      <= spuriousNext;
      INT           <= intNext;
      IRR           <= irrNext;
      ISR           <= isrNext;
      servicedLevel <= ackLevel;
      if (loadVector) begin
        dataOut      <= {vectorBase, servicedLevel};
        dataOutValid <= 1'b1;
      end else if (dropValid) begin
        dataOutValid <= 1'b0;
      end else begin
        dataOutValid <= dataOutValid;
      end
    end
  end

endmodule
